// File: rtl/sdram_responder.sv
// sdram_responder: cycle-level SDRAM device model. Decodes the command bus,
// tracks open rows per bank, and returns read data after the CAS latency.
module sdram_responder #(
   parameter int ROW_W      = 13,
   parameter int COL_W      = 10,
   parameter int BANK_W     = 2,
   parameter int DATA_W     = 16,
   parameter int MEM_AW     = 12,
   parameter int CL_DEFAULT = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cke,
   input  logic              cs_n,
   input  logic              ras_n,
   input  logic              cas_n,
   input  logic              we_n,
   input  logic [BANK_W-1:0] ba,
   input  logic [ROW_W-1:0]  addr,
   input  logic [1:0]        dqm,
   input  logic [DATA_W-1:0] dq_in,
   output logic [DATA_W-1:0] dq_out,
   output logic              dq_oe,
   output logic              init_done,
   output logic              cmd_error,
   output logic [7:0]        refresh_count
);

   localparam int unsigned NBANK = 1 << BANK_W;
   localparam int          HALF  = DATA_W / 2;

   typedef enum logic [2:0] {
      WAIT_PRE, WAIT_REF0, WAIT_REF1, WAIT_MODE, READY
   } state_t;

   typedef enum logic [2:0] {
      CMD_DESEL, CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF, CMD_MODE
   } cmd_t;

   state_t              r_state, w_state_nxt;
   cmd_t                w_cmd;
   logic [NBANK-1:0]    r_open;
   logic [ROW_W-1:0]    r_row [NBANK];
   logic [1:0]          r_cl;
   logic [DATA_W-1:0]   r_mem [2**MEM_AW];
   logic [2:0]          r_pv;
   logic [DATA_W-1:0]   r_pd [3];

   logic                w_any_open, w_mode_ok, w_err;
   logic                w_do_act, w_do_rd, w_do_wr, w_do_pre, w_do_ref, w_do_mode;
   logic [MEM_AW-1:0]   w_idx;
   logic [DATA_W-1:0]   w_word, w_wr_word, w_rd_masked;

   assign init_done  = (r_state == READY);
   assign w_any_open = |r_open;
   assign w_mode_ok  = (addr[2:0] == 3'b000) && ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3))
                       && !w_any_open;
   assign w_idx      = MEM_AW'({ba, r_row[ba], addr[COL_W-1:0]});
   assign w_word     = r_mem[w_idx];

   // Decode the sampled command pins; burst stop falls through to NOP
   always_comb begin
      w_cmd = CMD_NOP;
      casez ({cs_n, ras_n, cas_n, we_n})
         4'b1???: w_cmd = CMD_DESEL;
         4'b0011: w_cmd = CMD_ACT;
         4'b0101: w_cmd = CMD_READ;
         4'b0100: w_cmd = CMD_WRITE;
         4'b0010: w_cmd = CMD_PRE;
         4'b0001: w_cmd = CMD_REF;
         4'b0000: w_cmd = CMD_MODE;
         default: w_cmd = CMD_NOP;
      endcase
   end

   // Byte-lane merge for writes and lane masking for read data
   always_comb begin
      w_wr_word   = dq_in;
      w_rd_masked = w_word;
      if (dqm[1]) begin
         w_wr_word[DATA_W-1:HALF]   = w_word[DATA_W-1:HALF];
         w_rd_masked[DATA_W-1:HALF] = '0;
      end
      if (dqm[0]) begin
         w_wr_word[HALF-1:0]   = w_word[HALF-1:0];
         w_rd_masked[HALF-1:0] = '0;
      end
   end

   // Init FSM next state plus command legality and action strobes
   always_comb begin
      w_state_nxt = r_state;
      w_err       = 1'b0;
      w_do_act    = 1'b0;
      w_do_rd     = 1'b0;
      w_do_wr     = 1'b0;
      w_do_pre    = 1'b0;
      w_do_ref    = 1'b0;
      w_do_mode   = 1'b0;
      if (cke) begin
         case (w_cmd)
            CMD_ACT: begin
               if (r_state == READY && !r_open[ba]) w_do_act = 1'b1;
               else                                 w_err    = 1'b1;
            end
            CMD_READ: begin
               if (r_state == READY && r_open[ba]) w_do_rd = 1'b1;
               else                                w_err   = 1'b1;
            end
            CMD_WRITE: begin
               if (r_state == READY && r_open[ba]) w_do_wr = 1'b1;
               else                                w_err   = 1'b1;
            end
            CMD_PRE: begin
               if (r_state == READY) begin
                  w_do_pre = 1'b1;
               end else if (r_state == WAIT_PRE && addr[10]) begin
                  w_do_pre    = 1'b1;
                  w_state_nxt = WAIT_REF0;
               end else begin
                  w_err = 1'b1;
               end
            end
            CMD_REF: begin
               case (r_state)
                  WAIT_REF0: begin w_do_ref = 1'b1; w_state_nxt = WAIT_REF1; end
                  WAIT_REF1: begin w_do_ref = 1'b1; w_state_nxt = WAIT_MODE; end
                  READY: begin
                     if (w_any_open) w_err    = 1'b1;
                     else            w_do_ref = 1'b1;
                  end
                  default: w_err = 1'b1;
               endcase
            end
            CMD_MODE: begin
               if (r_state == WAIT_MODE || r_state == READY) begin
                  if (w_mode_ok) w_do_mode = 1'b1;
                  else           w_err     = 1'b1;
                  if (r_state == WAIT_MODE) w_state_nxt = READY;
               end else begin
                  w_err = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Init FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= WAIT_PRE;
      else          r_state <= w_state_nxt;
   end

   // Bank rows, CAS latency, refresh counter and sticky error flag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_open        <= '0;
         r_cl          <= 2'(CL_DEFAULT);
         refresh_count <= '0;
         cmd_error     <= 1'b0;
         for (int unsigned i = 0; i < NBANK; i++) r_row[i] <= '0;
      end else begin
         if (w_err) cmd_error <= 1'b1;
         if (w_do_act) begin
            r_open[ba] <= 1'b1;
            r_row[ba]  <= addr;
         end
         if (w_do_pre) begin
            if (addr[10]) r_open     <= '0;
            else          r_open[ba] <= 1'b0;
         end
         if (w_do_ref && refresh_count != 8'hFF) refresh_count <= refresh_count + 8'd1;
         if (w_do_mode) r_cl <= addr[5:4];
      end
   end

   // Backing store; contents survive reset
   always_ff @(posedge clock) begin
      if (w_do_wr) r_mem[w_idx] <= w_wr_word;
   end

   // Read pipeline shifting toward stage 0. A read is inserted at stage CL-1 so
   // it carries the latency in force when issued; later CL changes cannot
   // collide because LOAD MODE needs all banks closed between reads.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pv   <= '0;
         dq_oe  <= 1'b0;
         dq_out <= '0;
         for (int unsigned i = 0; i < 3; i++) r_pd[i] <= '0;
      end else if (cke) begin
         r_pv    <= {1'b0, r_pv[2:1]};
         r_pd[0] <= r_pd[1];
         r_pd[1] <= r_pd[2];
         r_pd[2] <= '0;
         if (w_do_rd) begin
            if (r_cl == 2'd3) begin
               r_pv[2] <= 1'b1;
               r_pd[2] <= w_rd_masked;
            end else begin
               r_pv[1] <= 1'b1;
               r_pd[1] <= w_rd_masked;
            end
         end
         dq_oe  <= r_pv[0];
         dq_out <= r_pv[0] ? r_pd[0] : '0;
      end
   end

endmodule
